spike_encoder: RTL

Input spike core for the tinyODIN subsystem. It holds one frame of input intensities and, for every tick published by the tick generator, scans all N inputs. For each input whose intensity matches the current tick it emits one AER event towards ODIN. It then raises `spikecore_done_o`, which the tick generator combines with ODIN's done to advance the tick.

---
 rtl/tinyodin_pkg.sv | 20 ++
 rtl/spike_cmp.sv | 19 +
 rtl/spike_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tinyodin_pkg.sv
// Shared tinyODIN types: spike-encoder FSM states, AER address type and the
// tick generator's starting value.
package tinyodin_pkg;

    localparam int AER_N  = 256;
    localparam int AER_AW = $clog2(AER_N);

    typedef logic [AER_AW-1:0] aer_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE
    } spk_enc_state_e;

    // Ticks count down from here, so the brightest pixel fires first.
    localparam logic [7:0] TICK_INIT = 8'd255;

endpackage

// File: rtl/spike_cmp.sv
// Spike-condition compare for one pixel against the current tick.
// Build option SPIKE_ENCODER_RATE_EN selects cumulative (>=) instead of time-to-first-spike (==) coding.
module spike_cmp
    import tinyodin_pkg::*;
#(
    parameter int INPUT_RESO = 8
) (
    input  logic [INPUT_RESO-1:0] pix,
    input  logic [INPUT_RESO-1:0] tick,
    output logic                  hit
);

`ifdef SPIKE_ENCODER_RATE_EN
    assign hit = (pix != '0) && (pix >= tick);
`else
    assign hit = (pix != '0) && (pix == tick);
`endif

endmodule

// File: rtl/spike_encoder.sv
// Input spike core: scans the stored frame once per tick and emits one AER event per matching pixel.
// Optional build macro SPIKE_ENCODER_RATE_EN (evaluated inside spike_cmp) enables cumulative coding.
module spike_encoder
    import tinyodin_pkg::*;
#(
    parameter int N          = 256,
    parameter int INPUT_RESO = 8,
    parameter int AW         = $clog2(N)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  pix_we_i,
    input  logic [AW-1:0]         pix_addr_i,
    input  logic [INPUT_RESO-1:0] pix_data_i,
    input  logic                  start_i,
    input  logic [INPUT_RESO-1:0] tick_i,
    input  logic                  next_tick_i,
    input  logic                  inference_done_i,
    output logic                  aer_valid_o,
    output logic [AW-1:0]         aer_addr_o,
    input  logic                  aer_ready_i,
    output logic                  spikecore_done_o,
    output logic                  busy_o
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    spk_enc_state_e        state, state_next;
    logic [AW-1:0]         idx, idx_next;
    logic [AW-1:0]         addr_q, addr_next;
    logic [INPUT_RESO-1:0] pix [N];
    logic                  hit;

    // The frame may only change while idle, so a scan always sees a stable image.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < N; i++) begin
                pix[i] <= '0;
            end
        end else if (pix_we_i && (state == IDLE)) begin
            pix[pix_addr_i] <= pix_data_i;
        end
    end

    spike_cmp #(
        .INPUT_RESO (INPUT_RESO)
    ) u_cmp (
        .pix  (pix[idx]),
        .tick (tick_i),
        .hit  (hit)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= IDLE;
            idx    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            addr_q <= addr_next;
        end
    end

    // Index N-1 always ends the scan, so idx never wraps within a tick.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        addr_next  = addr_q;
        if (inference_done_i) begin
            state_next = IDLE;
            idx_next   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        state_next = SCAN;
                        idx_next   = '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        state_next = EMIT;
                        addr_next  = idx;
                    end else if (idx == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (aer_ready_i) begin
                        if (idx == LAST_IDX) begin
                            state_next = DONE;
                        end else begin
                            state_next = SCAN;
                            idx_next   = idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (next_tick_i) begin
                        state_next = SCAN;
                        idx_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    assign aer_valid_o      = (state == EMIT);
    assign aer_addr_o       = addr_q;
    assign spikecore_done_o = (state == DONE);
    assign busy_o           = (state != IDLE);

endmodule
